// File: rtl/wakeup_bcast_arbiter_pkg.sv
// Shared constants and types for the wakeup broadcast arbiter slice.
package wakeup_pkg;

    localparam int PR_W       = 6;
    localparam int NUM_SRC    = 4;
    localparam int NUM_BCAST  = 2;
    localparam int FIFO_DEPTH = 2;

    localparam int SRC_ALU0 = 0;
    localparam int SRC_ALU1 = 1;
    localparam int SRC_AGU  = 2;
    localparam int SRC_BRU  = 3;

    typedef logic [PR_W-1:0] pr_tag_t;

    // Tag 0 never names a real destination; it means "no wakeup".
    localparam pr_tag_t PR_NONE = {PR_W{1'b0}};

endpackage

// File: rtl/wakeup_bcast_arbiter_if.sv
// Producer-side result bus and issue-queue-side wakeup broadcast bundle.
interface wakeup_bcast_arbiter_if;
    import wakeup_pkg::*;

    logic                      flush;
    logic [NUM_SRC-1:0]        src_vld;
    logic [NUM_SRC*PR_W-1:0]   src_pr;
    logic [NUM_SRC-1:0]        src_rdy;
    logic [NUM_BCAST-1:0]      bcast_vld;
    logic [NUM_BCAST*PR_W-1:0] bcast_pr;

    modport master (
        output flush, src_vld, src_pr,
        input  src_rdy, bcast_vld, bcast_pr
    );

    modport slave (
        input  flush, src_vld, src_pr,
        output src_rdy, bcast_vld, bcast_pr
    );
endinterface

// File: rtl/wakeup_bcast_arbiter_src.sv
// Per-producer tag FIFO; a full FIFO refuses a push even while being popped.
module wakeup_src_fifo #(
    parameter int FIFO_DEPTH = 2,
    parameter int PR_W       = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [PR_W-1:0] push_pr,
    input  logic            pop,
    input  logic            flush,
    output logic [PR_W-1:0] head_pr,
    output logic            empty,
    output logic            full
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PR_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (cnt_q == CNT_W'(0));
    assign head_pr   = mem_q[rd_ptr_q];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Storage array; contents are only meaningful below cnt_q.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) begin
            mem_q[wr_ptr_q] <= push_pr;
        end
    end

    // Pointer and occupancy state; flush behaves as a synchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            cnt_q    <= CNT_W'(0);
        end else if (flush) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            cnt_q    <= CNT_W'(0);
        end else begin
            if (do_push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/wakeup_bcast_arbiter.sv
// Rotating-priority arbiter draining per-producer tag FIFOs onto NUM_BCAST wakeup buses.
module wakeup_bcast_arbiter
    import wakeup_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    wakeup_bcast_arbiter_if.slave wk_if
);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [SRC_W-1:0]          rr_q;
    logic [SRC_W-1:0]          rr_d;
    logic [NUM_SRC-1:0]        push_s;
    logic [NUM_SRC-1:0]        pop_s;
    logic [NUM_SRC-1:0]        empty_s;
    logic [NUM_SRC-1:0]        full_s;
    pr_tag_t                   head_s [NUM_SRC];
    logic [NUM_BCAST-1:0]      bvld_s;
    logic [NUM_BCAST*PR_W-1:0] bpr_s;
    int                        idx_s;
    int                        ngrant_s;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign push_s[i] = wk_if.src_vld[i] & ~full_s[i] & ~wk_if.flush
                         & (wk_if.src_pr[i*PR_W +: PR_W] != PR_NONE);

        wakeup_src_fifo #(
            .FIFO_DEPTH (FIFO_DEPTH),
            .PR_W       (PR_W)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push    (push_s[i]),
            .push_pr (wk_if.src_pr[i*PR_W +: PR_W]),
            .pop     (pop_s[i]),
            .flush   (wk_if.flush),
            .head_pr (head_s[i]),
            .empty   (empty_s[i]),
            .full    (full_s[i])
        );
    end

    assign wk_if.src_rdy   = ~full_s;
    assign wk_if.bcast_vld = bvld_s;
    assign wk_if.bcast_pr  = bpr_s;

    // Scan from rr, handing buses in order to the first non-empty FIFOs.
    always_comb begin
        pop_s    = {NUM_SRC{1'b0}};
        bvld_s   = {NUM_BCAST{1'b0}};
        bpr_s    = {(NUM_BCAST*PR_W){1'b0}};
        rr_d     = rr_q;
        ngrant_s = 0;
        idx_s    = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx_s = (int'(rr_q) + k) % NUM_SRC;
            if (!empty_s[idx_s] && (ngrant_s < NUM_BCAST)) begin
                pop_s[idx_s]                  = 1'b1;
                bvld_s[ngrant_s]              = 1'b1;
                bpr_s[ngrant_s*PR_W +: PR_W]  = head_s[idx_s];
                rr_d                          = SRC_W'((idx_s + 1) % NUM_SRC);
                ngrant_s                      = ngrant_s + 1;
            end else begin
                ngrant_s = ngrant_s;
            end
        end
    end

    // Round-robin pointer; moves past the last winner, or holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= SRC_W'(0);
        end else if (wk_if.flush) begin
            rr_q <= SRC_W'(0);
        end else begin
            rr_q <= rr_d;
        end
    end
endmodule

// File: tb/tb_wakeup_bcast_arbiter.sv
// Directed self-checking bench for wakeup_bcast_arbiter.
module tb_wakeup_bcast_arbiter;
    import wakeup_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   fair_cnt [NUM_SRC];
    int   fair_last [NUM_SRC];
    int   fair_gap [NUM_SRC];

    wakeup_bcast_arbiter_if wk_if();

    wakeup_bcast_arbiter dut (
        .clk   (clk),
        .rst   (rst),
        .wk_if (wk_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wk_if.flush   = 1'b0;
        wk_if.src_vld = '0;
        wk_if.src_pr  = '0;
    endtask

    task automatic push(input int src, input int pr);
        wk_if.src_vld[src]              = 1'b1;
        wk_if.src_pr[src*PR_W +: PR_W]  = PR_W'(pr);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_bus(input string tag, input logic [1:0] vld, input int b0, input int b1);
        logic [31:0] pr_exp;
        pr_exp = (32'(b1) << PR_W) | 32'(b0);
        check_eq({tag, "_vld"}, 32'(wk_if.bcast_vld), 32'(vld));
        check_eq({tag, "_pr"},  32'(wk_if.bcast_pr),  pr_exp);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_rdy", 32'(wk_if.src_rdy), 32'hF);
        exp_bus("reset", 2'b00, 0, 0);
        rst = 1'b0;

        // Four-way contention from rr=0.
        push(SRC_ALU0, 5); push(SRC_ALU1, 9); push(SRC_AGU, 17); push(SRC_BRU, 33);
        tick(); idle();
        exp_bus("four_c1", 2'b11, 5, 9);
        tick();
        exp_bus("four_c2", 2'b11, 17, 33);
        tick();
        exp_bus("four_c3", 2'b00, 0, 0);

        // Backpressure: steer rr to AGU so ALU0 loses a cycle and fills up.
        push(SRC_ALU0, 60); push(SRC_ALU1, 61);
        tick(); idle();
        exp_bus("bp_p2", 2'b11, 60, 61);
        push(SRC_ALU0, 3); push(SRC_AGU, 40); push(SRC_BRU, 41);
        tick(); idle();
        exp_bus("bp_p3", 2'b11, 40, 41);
        check_eq("bp_p3_rdy", 32'(wk_if.src_rdy), 32'hF);
        push(SRC_ALU0, 4); push(SRC_AGU, 42); push(SRC_BRU, 43);
        tick(); idle();
        check_eq("bp_full_rdy", 32'(wk_if.src_rdy), 32'hE);
        exp_bus("bp_p4", 2'b11, 3, 42);
        push(SRC_ALU0, 6);
        tick(); idle();
        check_eq("bp_p5_rdy", 32'(wk_if.src_rdy), 32'hF);
        exp_bus("bp_p5", 2'b11, 43, 4);
        push(SRC_ALU0, 6);
        tick(); idle();
        exp_bus("bp_p6", 2'b01, 6, 0);
        tick();
        exp_bus("bp_p7", 2'b00, 0, 0);

        // Zero tag from BRU is a no-op.
        wk_if.src_vld[SRC_BRU] = 1'b1;
        tick(); idle();
        exp_bus("zero_tag", 2'b00, 0, 0);
        check_eq("zero_rdy", 32'(wk_if.src_rdy), 32'hF);
        tick();
        exp_bus("zero_tag2", 2'b00, 0, 0);

        // Flush collides with an ALU0 push; rr returns to 0.
        push(SRC_ALU1, 7); push(SRC_AGU, 12);
        tick(); idle();
        exp_bus("flush_cyc", 2'b11, 7, 12);
        wk_if.flush = 1'b1;
        push(SRC_ALU0, 21);
        tick(); idle();
        exp_bus("flush_after", 2'b00, 0, 0);
        check_eq("flush_rdy", 32'(wk_if.src_rdy), 32'hF);
        push(SRC_ALU0, 22); push(SRC_BRU, 23);
        tick(); idle();
        exp_bus("flush_rr0", 2'b11, 22, 23);
        tick();
        exp_bus("flush_drain", 2'b00, 0, 0);

        // Asynchronous reset with three tags pending.
        push(SRC_ALU0, 10); push(SRC_ALU1, 11); push(SRC_AGU, 13);
        tick(); idle();
        exp_bus("rst_pending", 2'b11, 10, 11);
        rst = 1'b1;
        #1;
        exp_bus("rst_async", 2'b00, 0, 0);
        check_eq("rst_async_rdy", 32'(wk_if.src_rdy), 32'hF);
        tick();
        rst = 1'b0;
        exp_bus("rst_rel", 2'b00, 0, 0);
        tick();
        exp_bus("rst_idle", 2'b00, 0, 0);

        // Fairness: every source valid for 40 cycles.
        for (int s = 0; s < NUM_SRC; s++) begin
            fair_cnt[s]  = 0;
            fair_last[s] = 0;
            fair_gap[s]  = 0;
        end
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) begin
                for (int j = 0; j < NUM_BCAST; j++) begin
                    if (wk_if.bcast_vld[j]) begin
                        int src;
                        src = int'(wk_if.bcast_pr[j*PR_W +: PR_W]) - 20;
                        check_eq("fair_tag", 32'((src >= 0) && (src < NUM_SRC)), 32'd1);
                        if ((src >= 0) && (src < NUM_SRC)) begin
                            fair_cnt[src]++;
                            if (c - fair_last[src] > fair_gap[src]) fair_gap[src] = c - fair_last[src];
                            fair_last[src] = c;
                        end
                    end
                end
            end
            for (int s = 0; s < NUM_SRC; s++) push(s, 20 + s);
            tick();
        end
        idle();
        for (int s = 0; s < NUM_SRC; s++) begin
            check_eq($sformatf("fair_cnt%0d", s), 32'((fair_cnt[s] >= 19) && (fair_cnt[s] <= 21)), 32'd1);
            check_eq($sformatf("fair_gap%0d", s), 32'(fair_gap[s] <= 2), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
